bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N, default 4: number of cache blocks sharing the snoop bus (2..8).
REQ-002 Parameter EW, default 5: CPU event width, one-hot {inv, wh, wm, rh, rm}.
REQ-003 Parameter BW, default 6: bus message width, {upper[2:0], lower[2:0]}.
REQ-004 CLK  in  1  single clock, all state updates on posedge.
REQ-005 CLR  in  1  asynchronous, active-high reset.
REQ-006 REQ  in  N  per-cache bus request, level, held until ACK.
REQ-007 CPU_event_in  in  N*EW  per-cache pending CPU event, slice i = bits [i*EW +: EW].
REQ-008 BUS_in  in  N*BW  per-cache BUS_out, slice i = bits [i*BW +: BW].
REQ-009 Controle  out  N  per-cache emitter select: high = emitter, low = listener.
REQ-010 CPU_event_out  out  N*EW  per-cache event driven into each cache block.
REQ-011 GRANT  out  N  one-hot winner, held from EMIT through SNOOP.
REQ-012 ACK  out  N  one-cycle completion pulse to the winner.
REQ-013 BUS_out  out  BW  last bus message captured from a winner.
REQ-014 BUSY  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE=2'b00, EMIT=2'b01, CAPTURE=2'b10 and SNOOP=2'b11.
REQ-016 IDLE: when REQ is nonzero, the FSM SHALL pick the winner round-robin from the pointer, latch GRANT and the winner's CPU_event_in slice, and go to EMIT. When REQ is zero it SHALL stay in IDLE.
REQ-017 EMIT (1 cycle): Controle[w]=1, CPU_event_out slice w = latched event, and all other slices zero. The FSM SHALL then go to CAPTURE.
REQ-018 CAPTURE (1 cycle): Controle SHALL be all zero and CPU_event_out all zero. BUS_out SHALL latch BUS_in slice w at the closing edge, and the FSM SHALL go to SNOOP.
REQ-019 SNOOP (1 cycle): Controle all zero. Every slice except w SHALL carry the translated event from REQ-020, and slice w SHALL be zero. ACK[w]=1 and the FSM SHALL go to IDLE.
REQ-020 Translation of BUS_out lower field: 3'b001→5'b00001; 3'b010→5'b00100; 3'b100→5'b10000; any other value→5'b00000. The upper field SHALL be ignored for translation.
REQ-021 Latency SHALL be fixed: REQ seen in IDLE at cycle t gives EMIT at t+1, CAPTURE at t+2, SNOOP/ACK at t+3 and IDLE at t+4, i.e. one grant per 4 cycles.
REQ-022 Round-robin: after each grant the pointer SHALL become (w+1) mod N. The search SHALL start at the pointer and wrap past N-1 to 0.
REQ-023 Simultaneous requests SHALL be resolved by REQ-022 only, with no fixed priority beyond pointer order.
REQ-024 REQ changes during EMIT, CAPTURE or SNOOP SHALL be ignored until the next IDLE. A winner deasserting REQ mid-transaction SHALL NOT abort it.
REQ-025 The winner's REQ still high in the IDLE after its ACK SHALL be treated as a new request and arbitrated normally.
REQ-026 GRANT and Controle SHALL never have more than one bit set. Controle SHALL be a subset of GRANT.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from REQ to outputs.
REQ-028 Listener-originated write-back messages (BUS_in of non-winners) SHALL NOT be captured. BUS_out holds only winner messages.

Reset
REQ-029 CLR=1 SHALL immediately force: state IDLE, pointer 0, GRANT 0, Controle 0, CPU_event_out 0, ACK 0, BUS_out 6'b000000, BUSY 0.
REQ-030 CLR asserted mid-transaction SHALL abandon it with no ACK. After release, arbitration SHALL restart from requester 0.

Structure
REQ-031 Package mesi_pkg SHALL hold: MESI state codes (I=001, S=010, E=011, M=100), CPU event one-hot constants, bus message codes (001 rm, 010 wm, 011 wb, 100 inv), FSM state encodings, and the bus-to-event translation function.
REQ-032 Sub-module rr_picker SHALL take (N-bit req, pointer) and return a one-hot winner plus a valid flag. It SHALL be purely combinational.
REQ-033 The RTL SHALL instantiate N bloco-compatible connections only through ports, with no cache instances inside bus_arbiter.

Verification
REQ-034 Single request: REQ=4'b0001, event 5'b00001 → Controle=0001 at t+1 with slice0=00001. Cache returns 000001, so at t+3 slices 1..3 = 00001, ACK=0001 and BUS_out=000001.
REQ-035 All request: REQ=4'b1111 held → grants in order 0,1,2,3,0 every 4 cycles, and GRANT is never multi-hot.
REQ-036 Write hit in S: winner BUS_in=6'b000100 → others get 5'b10000 at SNOOP, and the winner's slice is 0.
REQ-037 Unknown message: BUS_in=6'b001011 → BUS_out=001011 and all SNOOP slices 00000.
REQ-038 Reset mid-op: CLR during CAPTURE with winner 2 → all outputs 0 immediately. With REQ=4'b0100 still high, the next grant is to requester 2 via pointer 0 (not 3).
REQ-039 Drop REQ: winner deasserts REQ during EMIT → transaction completes and ACK still pulses at t+3.

Source files
------------

// File: rtl/mesi_pkg.sv
// Shared definitions for the MESI snoop-bus arbiter slice.
// Holds MESI state codes, one-hot CPU event codes, bus message codes,
// the arbiter FSM encoding and the bus-message to snoop-event translation.
package mesi_pkg;

  // MESI line states
  localparam logic [2:0] MesiI = 3'b001;
  localparam logic [2:0] MesiS = 3'b010;
  localparam logic [2:0] MesiE = 3'b011;
  localparam logic [2:0] MesiM = 3'b100;

  // CPU events, one-hot {inv, wh, wm, rh, rm}
  localparam logic [4:0] EvRm  = 5'b00001;
  localparam logic [4:0] EvRh  = 5'b00010;
  localparam logic [4:0] EvWm  = 5'b00100;
  localparam logic [4:0] EvWh  = 5'b01000;
  localparam logic [4:0] EvInv = 5'b10000;

  // Bus message codes (lower field of a bus message)
  localparam logic [2:0] BusRm  = 3'b001;
  localparam logic [2:0] BusWm  = 3'b010;
  localparam logic [2:0] BusWb  = 3'b011;
  localparam logic [2:0] BusInv = 3'b100;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StEmit    = 2'b01,
    StCapture = 2'b10,
    StSnoop   = 2'b11
  } arb_state_e;

  // Event seen by listeners for a captured bus message. Write-backs and
  // unknown codes produce no snoop event.
  function automatic logic [4:0] bus_to_event(input logic [2:0] msg);
    logic [4:0] ev;
    case (msg)
      BusRm:   ev = EvRm;
      BusWm:   ev = EvWm;
      BusInv:  ev = EvInv;
      default: ev = 5'b00000;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// req_i   : per-requester request bits
// ptr_i   : requester index where the search starts (wraps past N-1 to 0)
// gnt_o   : one-hot winner
// idx_o   : binary index of the winner
// valid_o : high when any request is present
module rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // Walk the search order backwards so the first hit from the pointer is the
  // last assignment and therefore wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % int'(N)]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + k) % int'(N)] = 1'b1;
        idx_o   = PW'((int'(ptr_i) + k) % int'(N));
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Snoop-bus arbiter for N MESI cache blocks.
// Each transaction takes four cycles: IDLE (arbitrate) -> EMIT (winner gets
// its CPU event and drives the bus) -> CAPTURE (winner message latched) ->
// SNOOP (listeners get the translated event, winner gets ACK) -> IDLE.
// Ports:
//   CLK, CLR       clock, asynchronous active-high reset
//   REQ            per-cache bus request (level)
//   CPU_event_in   per-cache pending CPU event, slice i = [i*EW +: EW]
//   BUS_in         per-cache bus message, slice i = [i*BW +: BW]
//   Controle       per-cache emitter select (EMIT only)
//   CPU_event_out  per-cache event driven into each cache block
//   GRANT          one-hot winner, held EMIT..SNOOP
//   ACK            one-cycle completion pulse to the winner (SNOOP)
//   BUS_out        last message captured from a winner
//   BUSY           high outside IDLE
// All outputs decode registered state only; REQ never reaches an output
// combinationally.
module bus_arbiter
  import mesi_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 5,
  parameter int unsigned BW = 6
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [N-1:0]    REQ,
  input  logic [N*EW-1:0] CPU_event_in,
  input  logic [N*BW-1:0] BUS_in,
  output logic [N-1:0]    Controle,
  output logic [N*EW-1:0] CPU_event_out,
  output logic [N-1:0]    GRANT,
  output logic [N-1:0]    ACK,
  output logic [BW-1:0]   BUS_out,
  output logic            BUSY
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  win_q, win_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [EW-1:0]  event_q, event_d;
  logic [BW-1:0]  bus_q, bus_d;

  logic [N-1:0]   pick_gnt;
  logic [PW-1:0]  pick_idx;
  logic           pick_valid;
  logic [EW-1:0]  snoop_ev;

  rr_picker #(
    .N  (N),
    .PW (PW)
  ) u_rr_picker (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      event_q <= '0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      grant_q <= grant_d;
      event_q <= event_d;
      bus_q   <= bus_d;
    end
  end

  // REQ is only looked at in IDLE, so mid-transaction changes are ignored.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    grant_d = grant_q;
    event_d = event_q;
    bus_d   = bus_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StEmit;
          grant_d = pick_gnt;
          win_d   = pick_idx;
          event_d = CPU_event_in[int'(pick_idx)*EW +: EW];
          ptr_d   = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      StEmit: begin
        state_d = StCapture;
      end
      StCapture: begin
        // Only the winner slice is sampled; listener write-backs are dropped.
        bus_d   = BUS_in[int'(win_q)*BW +: BW];
        state_d = StSnoop;
      end
      StSnoop: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign snoop_ev = EW'(bus_to_event(bus_q[2:0]));

  always_comb begin
    Controle      = '0;
    CPU_event_out = '0;
    ACK           = '0;
    case (state_q)
      StEmit: begin
        Controle = grant_q;
        CPU_event_out[int'(win_q)*EW +: EW] = event_q;
      end
      StSnoop: begin
        ACK = grant_q;
        for (int i = 0; i < int'(N); i++) begin
          if (PW'(i) != win_q) begin
            CPU_event_out[i*EW +: EW] = snoop_ev;
          end
        end
      end
      default: ;
    endcase
  end

  assign GRANT   = grant_q;
  assign BUS_out = bus_q;
  assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter. A transaction-level model pushes the
// expected EMIT and SNOOP views into queues; a monitor on the falling edge
// pops and compares whenever the DUT shows Controle or ACK activity.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int EW = 5;
  localparam int BW = 6;

  logic            CLK;
  logic            CLR;
  logic [N-1:0]    REQ;
  logic [N*EW-1:0] CPU_event_in;
  logic [N*BW-1:0] BUS_in;
  logic [N-1:0]    Controle;
  logic [N*EW-1:0] CPU_event_out;
  logic [N-1:0]    GRANT;
  logic [N-1:0]    ACK;
  logic [BW-1:0]   BUS_out;
  logic            BUSY;

  bus_arbiter #(
    .N  (N),
    .EW (EW),
    .BW (BW)
  ) dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .REQ           (REQ),
    .CPU_event_in  (CPU_event_in),
    .BUS_in        (BUS_in),
    .Controle      (Controle),
    .CPU_event_out (CPU_event_out),
    .GRANT         (GRANT),
    .ACK           (ACK),
    .BUS_out       (BUS_out),
    .BUSY          (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int              stamp;
    logic [N-1:0]    oh;
    logic [N*EW-1:0] ev;
    logic [BW-1:0]   bus;
  } exp_t;

  exp_t emit_q[$];
  exp_t snoop_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  int m_left = 0;
  int m_win  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] xlate(input logic [2:0] l);
    case (l)
      3'b001:  return 5'b00001;
      3'b010:  return 5'b00100;
      3'b100:  return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_left = 0;
    emit_q.delete();
    snoop_q.delete();
  endtask

  // Reference model: one grant per four cycles, round-robin from a pointer.
  initial begin
    exp_t e;
    int   w;
    forever begin
      @(posedge CLK);
      if (CLR) begin
        model_reset();
      end else begin
        cyc++;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 1) begin
            e.stamp = cyc;
            e.oh    = '0;
            e.oh[m_win] = 1'b1;
            e.bus   = BUS_in[m_win*BW +: BW];
            e.ev    = '0;
            for (int i = 0; i < N; i++)
              if (i != m_win) e.ev[i*EW +: EW] = xlate(e.bus[2:0]);
            snoop_q.push_back(e);
          end
        end else if (REQ != 0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && REQ[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          m_win  = w;
          m_ptr  = (w + 1) % N;
          m_left = 3;
          e.stamp = cyc;
          e.oh    = '0;
          e.oh[w] = 1'b1;
          e.ev    = '0;
          e.ev[w*EW +: EW] = CPU_event_in[w*EW +: EW];
          e.bus   = '0;
          emit_q.push_back(e);
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!CLR) begin
        chk("grant_onehot", 64'($countones(GRANT) <= 1), 64'd1);
        chk("ctrl_subset_grant", 64'(Controle & ~GRANT), 64'd0);
        chk("busy", 64'(BUSY), 64'(m_left != 0));
        if (m_left == 0)
          chk("idle_outputs", {Controle, ACK, GRANT, CPU_event_out}, 64'd0);
        if (m_left == 2)
          chk("capture_outputs", {Controle, ACK, CPU_event_out}, 64'd0);

        if (Controle != 0) begin
          if (emit_q.size() == 0) begin
            chk("emit_unexpected", 64'(Controle), 64'd0);
          end else begin
            e = emit_q.pop_front();
            chk("emit_time", 64'(cyc), 64'(e.stamp));
            chk("emit_controle", 64'(Controle), 64'(e.oh));
            chk("emit_grant", 64'(GRANT), 64'(e.oh));
            chk("emit_event", 64'(CPU_event_out), 64'(e.ev));
            chk("emit_ack", 64'(ACK), 64'd0);
          end
        end else if (emit_q.size() != 0 && emit_q[0].stamp <= cyc) begin
          e = emit_q.pop_front();
          chk("emit_missing", 64'(Controle), 64'(e.oh));
        end

        if (ACK != 0) begin
          if (snoop_q.size() == 0) begin
            chk("ack_unexpected", 64'(ACK), 64'd0);
          end else begin
            e = snoop_q.pop_front();
            chk("snoop_time", 64'(cyc), 64'(e.stamp));
            chk("snoop_ack", 64'(ACK), 64'(e.oh));
            chk("snoop_grant", 64'(GRANT), 64'(e.oh));
            chk("snoop_controle", 64'(Controle), 64'd0);
            chk("snoop_bus_out", 64'(BUS_out), 64'(e.bus));
            chk("snoop_event", 64'(CPU_event_out), 64'(e.ev));
          end
        end else if (snoop_q.size() != 0 && snoop_q[0].stamp <= cyc) begin
          e = snoop_q.pop_front();
          chk("ack_missing", 64'(ACK), 64'(e.oh));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      CPU_event_in[i*EW +: EW] = EW'(1) << $urandom_range(0, EW - 1);
      BUS_in[i*BW +: BW]       = BW'($urandom_range(0, 63));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_controle"}, 64'(Controle), 64'd0);
    chk({tag, "_event_out"}, 64'(CPU_event_out), 64'd0);
    chk({tag, "_grant"}, 64'(GRANT), 64'd0);
    chk({tag, "_ack"}, 64'(ACK), 64'd0);
    chk({tag, "_bus_out"}, 64'(BUS_out), 64'd0);
    chk({tag, "_busy"}, 64'(BUSY), 64'd0);
  endtask

  initial begin
    CLR = 1'b1;
    REQ = '0;
    CPU_event_in = '0;
    BUS_in = '0;
    step(2);
    chk_all_zero("reset");
    CLR = 1'b0;

    // Single request from cache 0 with a read-miss round trip
    rand_inputs();
    REQ = 4'b0001;
    CPU_event_in[0 +: EW] = 5'b00001;
    BUS_in[0 +: BW] = 6'b000001;
    step(4);
    REQ = '0;
    step(2);

    // Write hit in S from cache 1: listeners see invalidate
    REQ = 4'b0010;
    BUS_in[1*BW +: BW] = 6'b000100;
    step(4);
    REQ = '0;
    step(1);

    // Unknown message from cache 2: captured verbatim, no snoop events
    REQ = 4'b0100;
    BUS_in[2*BW +: BW] = 6'b001011;
    step(4);
    REQ = '0;
    step(2);

    // All requesting: rotation, with inputs changing every cycle
    REQ = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      rand_inputs();
      step(1);
    end
    REQ = '0;
    for (int i = 0; i < 8 && m_left != 0; i++) step(1);

    // Winner drops REQ during EMIT
    REQ = 4'b1000;
    step(1);
    REQ = '0;
    step(5);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      REQ = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      step(1);
    end
    REQ = '0;
    for (int i = 0; i < 8 && m_left != 0; i++) step(1);

    // Reset during CAPTURE with winner 2, then restart from pointer 0
    REQ = 4'b0100;
    step(2);
    chk("pre_reset_grant", 64'(GRANT), 64'b0100);
    CLR = 1'b1;
    model_reset();
    #1;
    chk_all_zero("midreset");
    REQ = 4'b1100;
    step(1);
    CLR = 1'b0;
    step(6);
    REQ = '0;

    step(8);
    chk("emit_queue_drained", 64'(emit_q.size()), 64'd0);
    chk("snoop_queue_drained", 64'(snoop_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
